acc_job_arbiter: RTL and testbench

- Shares one custom accelerator (start-level in / finish-level out) between NUM_REQ requesters, e.g. HPS PIO channels.
- Per job: round-robin grant, one-cycle start pulse, wait for the accelerator's finish rising edge, then a done pulse to the owner.
- A watchdog aborts hung jobs. Job count and last-job latency are exported for software.

---
 rtl/acc_job_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_acc_job_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_job_arbiter.sv
// acc_job_arbiter: round-robin sharing of one start/finish accelerator between
// NUM_REQ requesters, with a per-job watchdog and software-visible statistics.
module acc_job_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CICLOS = 100000000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [NUM_REQ-1:0] o_done,
    output logic [NUM_REQ-1:0] o_timeout,
    output logic               o_acc_start,
    input  logic               i_acc_finish,
    output logic               o_busy,
    output logic [CNT_W-1:0]   o_jobs_done,
    output logic [15:0]        o_timeout_count,
    output logic [CNT_W-1:0]   o_last_latency
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned POS_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CICLOS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_DONE1,
        ST_DONE2,
        ST_RECOVER
    } state_t;

    state_t state;
    state_t state_next;

    logic [IDX_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   cnt;
    logic               finish_q;
    logic               rise;

    logic               win_valid;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   win_next;
    logic [NUM_REQ-1:0] win_onehot;
    logic [POS_W-1:0]   pos;

    logic [IDX_W-1:0]   rr_ptr_d;
    logic [CNT_W-1:0]   cnt_d;
    logic [NUM_REQ-1:0] grant_d;
    logic [NUM_REQ-1:0] done_d;
    logic [NUM_REQ-1:0] timeout_d;
    logic               start_d;
    logic               busy_d;
    logic [CNT_W-1:0]   jobs_done_d;
    logic [15:0]        timeout_count_d;
    logic [CNT_W-1:0]   last_latency_d;

    // Accelerator finish edge; the previous job's stale-high level never counts
    assign rise = i_acc_finish & ~finish_q;

    // Round-robin winner: first requester at or after rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        pos       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = POS_W'(rr_ptr) + POS_W'(k);
            if (pos >= POS_W'(NUM_REQ)) begin
                pos = pos - POS_W'(NUM_REQ);
            end
            if (!win_valid && i_req[pos[IDX_W-1:0]]) begin
                win_valid = 1'b1;
                win_idx   = pos[IDX_W-1:0];
            end
        end
        win_next   = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
        win_onehot = NUM_REQ'(1) << win_idx;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; completion takes priority over the watchdog in WAIT
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (win_valid) state_next = ST_START;
            ST_START:   state_next = ST_WAIT;
            ST_WAIT: begin
                if (rise) begin
                    state_next = ST_DONE1;
                end else if (cnt == CNT_LAST) begin
                    state_next = ST_RECOVER;
                end
            end
            ST_DONE1:   state_next = ST_DONE2;
            ST_DONE2:   state_next = ST_IDLE;
            ST_RECOVER: if (rise) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        rr_ptr_d        = rr_ptr;
        cnt_d           = cnt;
        grant_d         = o_grant;
        done_d          = '0;
        timeout_d       = '0;
        start_d         = 1'b0;
        busy_d          = (state_next != ST_IDLE);
        jobs_done_d     = o_jobs_done;
        timeout_count_d = o_timeout_count;
        last_latency_d  = o_last_latency;
        case (state)
            ST_IDLE: begin
                if (win_valid) begin
                    grant_d  = win_onehot;
                    rr_ptr_d = win_next;
                    start_d  = 1'b1;
                    cnt_d    = '0;
                end
            end
            ST_WAIT: begin
                if (rise) begin
                    done_d         = o_grant;
                    grant_d        = '0;
                    jobs_done_d    = o_jobs_done + CNT_W'(1);
                    last_latency_d = cnt + CNT_W'(1);
                end else if (cnt == CNT_LAST) begin
                    timeout_d       = o_grant;
                    grant_d         = '0;
                    timeout_count_d = o_timeout_count + 16'd1;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Output and datapath registers; reset abandons any job without a pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr          <= '0;
            cnt             <= '0;
            finish_q        <= 1'b0;
            o_grant         <= '0;
            o_done          <= '0;
            o_timeout       <= '0;
            o_acc_start     <= 1'b0;
            o_busy          <= 1'b0;
            o_jobs_done     <= '0;
            o_timeout_count <= '0;
            o_last_latency  <= '0;
        end else begin
            rr_ptr          <= rr_ptr_d;
            cnt             <= cnt_d;
            finish_q        <= i_acc_finish;
            o_grant         <= grant_d;
            o_done          <= done_d;
            o_timeout       <= timeout_d;
            o_acc_start     <= start_d;
            o_busy          <= busy_d;
            o_jobs_done     <= jobs_done_d;
            o_timeout_count <= timeout_count_d;
            o_last_latency  <= last_latency_d;
        end
    end

endmodule

// File: tb/tb_acc_job_arbiter.sv
// Bench for acc_job_arbiter: request rounds drive a behavioural accelerator;
// expected pulses are queued per round and checked by an independent monitor.
module tb_acc_job_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned T  = 12;
    localparam int unsigned CW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NR-1:0] i_req = '0;
    logic [NR-1:0] o_grant;
    logic [NR-1:0] o_done;
    logic [NR-1:0] o_timeout;
    logic          o_acc_start;
    logic          i_acc_finish = 1'b0;
    logic          o_busy;
    logic [CW-1:0] o_jobs_done;
    logic [15:0]   o_timeout_count;
    logic [CW-1:0] o_last_latency;

    acc_job_arbiter #(
        .NUM_REQ(NR),
        .TIMEOUT_CICLOS(T),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_req(i_req),
        .o_grant(o_grant),
        .o_done(o_done),
        .o_timeout(o_timeout),
        .o_acc_start(o_acc_start),
        .i_acc_finish(i_acc_finish),
        .o_busy(o_busy),
        .o_jobs_done(o_jobs_done),
        .o_timeout_count(o_timeout_count),
        .o_last_latency(o_last_latency)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_to;
        logic [3:0]  owner;
        int          n;
        int          lat;
        int          jobs;
        int          tcnt;
        bit          b2b;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];

    int errors = 0;
    int checks = 0;

    // Reference model state: round-robin pointer and counters
    int rrp    = 0;
    int jobs_m = 0;
    int tcnt_m = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Accelerator: after seeing start it holds finish low, then raises it so
    // the arbiter observes the edge in its (N+1)-th WAIT cycle; finish stays high
    int acc_n    = 0;
    int acc_cnt  = 0;
    bit acc_busy = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                acc_busy     = 1'b0;
                i_acc_finish = 1'b0;
            end else if (o_acc_start) begin
                if (acc_q.size() == 0) begin
                    chk("acc_start_expected", 1, 0);
                    acc_n = 5;
                end else begin
                    acc_n = acc_q.pop_front();
                end
                i_acc_finish = 1'b0;
                acc_cnt      = 0;
                acc_busy     = 1'b1;
            end else if (acc_busy) begin
                acc_cnt++;
                if (acc_cnt == acc_n + 1) begin
                    i_acc_finish = 1'b1;
                    acc_busy     = 1'b0;
                end
            end
        end
    end

    // Monitor: pops one expectation per done/timeout pulse and checks timing
    int         cyc      = 0;
    int         gv       = 0;
    int         want_gnt = 0;
    logic [3:0] pg       = '0;
    logic       ps       = 1'b0;
    exp_t       me;
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                pg       = '0;
                ps       = 1'b0;
                want_gnt = 0;
            end else begin
                if (o_acc_start) chk("start_one_cycle", ps, 0);
                if (o_grant != 0 && pg == 0) begin
                    gv = cyc;
                    chk("start_with_grant", o_acc_start, 1);
                    chk("grant_onehot", $countones(o_grant), 1);
                    if (want_gnt != 0) chk("b2b_grant_cycle", cyc, want_gnt);
                    want_gnt = 0;
                end
                if ((o_done | o_timeout) != 0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pulse", {o_done, o_timeout}, 0);
                    end else begin
                        me = exp_q.pop_front();
                        chk("done_vec", o_done, me.is_to ? 0 : me.owner);
                        chk("timeout_vec", o_timeout, me.is_to ? me.owner : 0);
                        chk("grant_cleared", o_grant, 0);
                        chk("busy_during_pulse", o_busy, 1);
                        chk("jobs_done", o_jobs_done, me.jobs);
                        chk("timeout_count", o_timeout_count, me.tcnt);
                        if (!me.is_to) begin
                            chk("last_latency", o_last_latency, me.lat);
                            // N+3 cycles counted from the IDLE cycle that issued the grant
                            chk("grant_to_done", cyc - gv, me.n + 2);
                        end else begin
                            chk("grant_to_timeout", cyc - gv, T + 1);
                        end
                        // Next grant issued 2 cycles after done, visible one cycle later
                        want_gnt = me.b2b ? cyc + 3 : 0;
                    end
                end
                pg = o_grant;
                ps = o_acc_start;
            end
        end
    end

    task automatic check_reset_outs(input string tag);
        chk({tag, "_grant"}, o_grant, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_timeout"}, o_timeout, 0);
        chk({tag, "_start"}, o_acc_start, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_jobs"}, o_jobs_done, 0);
        chk({tag, "_tcount"}, o_timeout_count, 0);
        chk({tag, "_latency"}, o_last_latency, 0);
    endtask

    // One round: requesters in s raise together while idle; nfix>0 fixes the
    // accelerator cycles, 0 picks 1..22, -1 picks a length that always completes
    task automatic run_round(input logic [3:0] s, input int nfix);
        int   order[$];
        int   n;
        int   last;
        int   budget;
        exp_t e;
        last = rrp;
        for (int i = 0; i < NR; i++) begin
            int idx;
            idx = (rrp + i) % NR;
            if (s[idx]) order.push_back(idx);
        end
        foreach (order[j]) begin
            if (nfix > 0)       n = nfix;
            else if (nfix == 0) n = int'($urandom_range(22, 1));
            else                n = int'($urandom_range(T - 1, 1));
            acc_q.push_back(n);
            e.owner = 4'(1 << order[j]);
            e.n     = n;
            if (n + 1 <= T) begin
                jobs_m++;
                e.is_to = 1'b0;
                e.lat   = n + 1;
            end else begin
                tcnt_m++;
                e.is_to = 1'b1;
                e.lat   = 0;
            end
            e.jobs = jobs_m;
            e.tcnt = tcnt_m & 16'hFFFF;
            e.b2b  = !e.is_to && (j != order.size() - 1);
            exp_q.push_back(e);
            last = order[j];
        end
        rrp   = (last + 1) % NR;
        i_req = s;
        budget = 0;
        while ((i_req != 0 || o_busy) && budget < 600) begin
            @(negedge clk);
            i_req = i_req & ~(o_done | o_timeout);
            budget++;
        end
        chk("round_in_budget", budget < 600, 1);
        if (budget >= 600) begin
            i_req = '0;
            exp_q.delete();
            acc_q.delete();
        end
        chk("round_drained", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Reset in the middle of WAIT: job vanishes with no pulse, model restarts
    task automatic reset_mid_job();
        int b;
        acc_q.push_back(15);
        i_req = 4'b0001;
        b = 0;
        while (o_grant == 0 && b < 20) begin
            @(negedge clk);
            b++;
        end
        chk("reset_job_granted", o_grant != 0, 1);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        i_req = '0;
        @(negedge clk);
        check_reset_outs("midreset");
        reset  = 1'b0;
        rrp    = 0;
        jobs_m = 0;
        tcnt_m = 0;
        acc_q.delete();
        repeat (20) @(negedge clk);
        chk("reset_stays_idle", o_busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outs("reset");
        reset = 1'b0;
        @(negedge clk);
        run_round(4'b0001, 10);
        run_round(4'b1111, -1);
        run_round(4'b0001, 4);
        run_round(4'b0001, 20);
        run_round(4'b0010, 4);
        run_round(4'b0001, T - 1);
        run_round(4'b0001, T);
        run_round(4'b0100, 6);
        run_round(4'b0100, 6);
        reset_mid_job();
        run_round(4'b0101, 6);
        run_round(4'b0100, 8);
        for (int r = 0; r < 20; r++) begin
            run_round(4'($urandom_range(15, 1)), 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
